// File: rtl/cmac_lbus2axi_if.sv
// cmac_lbus2axi_if: LBUS RX segment bus plus 512-bit AXI4-Stream output bus of cmac_lbus2axi
interface cmac_lbus2axi_if;
   logic [3:0][127:0] rx_data;
   logic [3:0]        rx_ena;
   logic [3:0]        rx_sop;
   logic [3:0]        rx_eop;
   logic [3:0]        rx_err;
   logic [3:0][3:0]   rx_mty;
   logic [511:0]      tdata;
   logic [63:0]       tkeep;
   logic              tvalid;
   logic              tlast;
   logic              tuser;
   logic              tready;
   // master: the converter (consumes LBUS, drives the stream)
   modport master (
      input  rx_data, rx_ena, rx_sop, rx_eop, rx_err, rx_mty, tready,
      output tdata, tkeep, tvalid, tlast, tuser
   );
   // slave: the environment (drives LBUS, sinks the stream)
   modport slave (
      output rx_data, rx_ena, rx_sop, rx_eop, rx_err, rx_mty, tready,
      input  tdata, tkeep, tvalid, tlast, tuser
   );
endinterface

// File: rtl/cmac_lbus2axi.sv
// cmac_lbus2axi: packs 4x128b LBUS RX segments into packet-aligned 512b AXI4-Stream beats via a 2-write FIFO
// Define CMAC_LBUS2AXI_ERR_FLAG_EN to drive tuser with packet error / truncation status (else tuser = 0).
module cmac_lbus2axi #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   cmac_lbus2axi_if.master       bus_io,
   output logic [31:0]           ovf_drop_cnt_o
);
`ifdef CMAC_LBUS2AXI_ERR_FLAG_EN
   localparam bit ErrEn = 1'b1;
`else
   localparam bit ErrEn = 1'b0;
`endif
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic {IDLE, IN_PKT} state_t;
   state_t            st_q, st_d;
   logic [3:0]        ena_q, sop_q, eop_q, err_q;
   logic [3:0][3:0]   mty_q;
   logic [3:0][127:0] data_q;
   logic [383:0]      acc_q, acc_d;
   logic [1:0]        n_q, n_d;
   logic              perr_q, perr_d, drop_q, drop_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [AW:0]       wp_q, rp_q, fill;
   logic [1:0][511:0] bd;
   logic [1:0][63:0]  bk;
   logic [1:0]        bl, bu, nw;
   logic [577:0]      mem_q [FIFO_DEPTH];
   logic [577:0]      head;
   logic              valid, pop;

   function automatic logic [127:0] bswap(input logic [127:0] d);
      for (int j = 0; j < 16; j++) bswap[8*j +: 8] = d[127-8*j -: 8];
   endfunction

   function automatic logic [63:0] keep_of(input logic [6:0] nb);
      return ~({64{1'b1}} << nb);
   endfunction

   // free entries are judged on the occupancy at cycle start; a same-cycle pop is ignored (conservative)
   function automatic logic room_ok(input logic [AW:0] f, input logic [1:0] w, input int need);
      return w < 2'd2 && (FIFO_DEPTH - int'(f) - int'(w)) >= need;
   endfunction

   assign fill           = wp_q - rp_q;
   assign valid          = fill != '0;
   assign pop            = valid & bus_io.tready;
   assign head           = mem_q[rp_q[AW-1:0]];
   assign bus_io.tvalid  = valid;
   assign {bus_io.tuser, bus_io.tlast, bus_io.tkeep, bus_io.tdata} = valid ? head : '0;
   assign ovf_drop_cnt_o = cnt_q;

   // walk the four registered segments in order, packing them into beats and deciding up to two FIFO writes
   always_comb begin
      logic [511:0] acc;
      logic [2:0]   n;
      logic [1:0]   w;
      logic [3:0]   inc;
      logic [32:0]  sum;
      st_d   = st_q;
      perr_d = perr_q;
      drop_d = drop_q;
      acc    = {128'b0, acc_q};
      n      = {1'b0, n_q};
      w      = '0;
      inc    = '0;
      bd     = '0;
      bk     = '0;
      bl     = '0;
      bu     = '0;
      for (int k = 0; k < 4; k++) begin
         if (ena_q[k] && sop_q[k]) begin
            if (st_d == IN_PKT && !drop_d) begin
               if (room_ok(fill, w, 1)) begin
                  bd[w[0]] = acc;
                  bk[w[0]] = keep_of({n, 4'b0});
                  bl[w[0]] = 1'b1;
                  bu[w[0]] = ErrEn;
                  w = w + 2'd1;
               end else inc = inc + 4'd1;
            end
            st_d   = IN_PKT;
            drop_d = 1'b0;
            perr_d = 1'b0;
            n      = '0;
            acc    = '0;
         end
         if (ena_q[k] && st_d == IN_PKT && drop_d) begin
            if (eop_q[k]) begin
               st_d   = IDLE;
               drop_d = 1'b0;
            end
         end else if (ena_q[k] && st_d == IN_PKT) begin
            acc[128*n +: 128] = bswap(data_q[k]);
            n      = n + 3'd1;
            perr_d = perr_d | err_q[k];
            if (eop_q[k]) begin
               if (room_ok(fill, w, 1)) begin
                  bd[w[0]] = acc;
                  bk[w[0]] = keep_of({n, 4'b0} - {3'b0, mty_q[k]});
                  bl[w[0]] = 1'b1;
                  bu[w[0]] = ErrEn & perr_d;
                  w = w + 2'd1;
               end else inc = inc + 4'd1;
               st_d = IDLE;
               n    = '0;
               acc  = '0;
            end else if (n == 3'd4) begin
               if (room_ok(fill, w, 3)) begin
                  bd[w[0]] = acc;
                  bk[w[0]] = '1;
                  bl[w[0]] = 1'b0;
                  bu[w[0]] = 1'b0;
                  w = w + 2'd1;
               end else begin
                  if (room_ok(fill, w, 1)) begin
                     bd[w[0]] = acc;
                     bk[w[0]] = '1;
                     bl[w[0]] = 1'b1;
                     bu[w[0]] = ErrEn;
                     w = w + 2'd1;
                  end
                  inc    = inc + 4'd1;
                  drop_d = 1'b1;
               end
               n   = '0;
               acc = '0;
            end
         end
      end
      sum   = {1'b0, cnt_q} + 33'(inc);
      cnt_d = sum[32] ? '1 : sum[31:0];
      n_d   = n[1:0];
      acc_d = acc[383:0];
      nw    = w;
   end

   // input stage, packet state, drop counter and FIFO pointers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ena_q  <= '0;
         sop_q  <= '0;
         eop_q  <= '0;
         err_q  <= '0;
         mty_q  <= '0;
         data_q <= '0;
         st_q   <= IDLE;
         acc_q  <= '0;
         n_q    <= '0;
         perr_q <= 1'b0;
         drop_q <= 1'b0;
         cnt_q  <= '0;
         wp_q   <= '0;
         rp_q   <= '0;
      end else begin
         ena_q  <= bus_io.rx_ena;
         sop_q  <= bus_io.rx_sop;
         eop_q  <= bus_io.rx_eop;
         err_q  <= bus_io.rx_err;
         mty_q  <= bus_io.rx_mty;
         data_q <= bus_io.rx_data;
         st_q   <= st_d;
         acc_q  <= acc_d;
         n_q    <= n_d;
         perr_q <= perr_d;
         drop_q <= drop_d;
         cnt_q  <= cnt_d;
         wp_q   <= wp_q + (AW+1)'(nw);
         rp_q   <= rp_q + (AW+1)'(pop);
      end
   end

   // FIFO storage with two write ports; stale entries are hidden by valid gating on the outputs
   always_ff @(posedge clk_i) begin
      if (nw != 2'd0) mem_q[wp_q[AW-1:0]] <= {bu[0], bl[0], bk[0], bd[0]};
      if (nw == 2'd2) mem_q[wp_q[AW-1:0] + AW'(1)] <= {bu[1], bl[1], bk[1], bd[1]};
   end
endmodule

// File: tb/tb_cmac_lbus2axi.sv
// tb_cmac_lbus2axi: directed LBUS packet stimulus with a beat scoreboard checked against the AXI output
module tb_cmac_lbus2axi;
`ifdef CMAC_LBUS2AXI_ERR_FLAG_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif
   typedef struct packed {
      logic         v;
      logic [127:0] d;
      logic         s;
      logic         e;
      logic         r;
      logic [3:0]   m;
   } seg_t;
   typedef struct packed {
      logic [511:0] d;
      logic [63:0]  k;
      logic         l;
      logic         u;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ovf;
   int          npass = 0;
   int          ntot = 0;
   seg_t        segq[$];
   beat_t       exp_q[$];

   cmac_lbus2axi_if bus ();

   cmac_lbus2axi #(.FIFO_DEPTH(8)) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .bus_io         (bus),
      .ovf_drop_cnt_o (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] want);
      ntot++;
      assert (obs === want) npass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, want);
   endtask

   // build LBUS segments for one packet and push the beats the converter must produce
   task automatic add_pkt(input int len, input int err_seg, input bit no_eop, input int trunc);
      logic [7:0] pb [2048];
      int         nseg, nb_tot, nbeats, idx;
      logic [7:0] base;
      seg_t       g;
      beat_t      e;
      base = 8'($urandom);
      nseg = (len + 15) / 16;
      for (int i = 0; i < 2048; i++) pb[i] = base + 8'(i * 7);
      for (int s = 0; s < nseg; s++) begin
         g   = '0;
         g.v = 1'b1;
         for (int j = 0; j < 16; j++) begin
            idx = 16 * s + j;
            if (idx < len) g.d[127-8*j -: 8] = pb[idx];
         end
         g.s = (s == 0);
         g.e = !no_eop && (s == nseg - 1);
         g.r = (s == err_seg);
         g.m = g.e ? 4'(16 * nseg - len) : 4'd0;
         segq.push_back(g);
      end
      nb_tot = no_eop ? 16 * nseg : len;
      nbeats = (trunc > 0) ? trunc : (nb_tot + 63) / 64;
      for (int t = 0; t < nbeats; t++) begin
         e = '0;
         for (int j = 0; j < 64; j++) begin
            idx = 64 * t + j;
            if (idx < nb_tot) begin
               e.d[8*j +: 8] = (idx < len) ? pb[idx] : 8'h00;
               e.k[j] = 1'b1;
            end
         end
         e.l = (t == nbeats - 1);
         e.u = EE && e.l && (err_seg >= 0 || no_eop || trunc > 0);
         exp_q.push_back(e);
      end
   endtask

   task automatic pad(input int n);
      for (int i = 0; i < n; i++) segq.push_back('0);
   endtask

   task automatic drive_cycle();
      seg_t g;
      for (int i = 0; i < 4; i++) begin
         g = '0;
         if (segq.size() != 0) g = segq.pop_front();
         bus.rx_ena[i]  = g.v;
         bus.rx_data[i] = g.d;
         bus.rx_sop[i]  = g.s;
         bus.rx_eop[i]  = g.e;
         bus.rx_err[i]  = g.r;
         bus.rx_mty[i]  = g.m;
      end
      @(posedge clk);
      #1;
      bus.rx_ena = '0;
      bus.rx_sop = '0;
      bus.rx_eop = '0;
      bus.rx_err = '0;
   endtask

   task automatic run();
      while (segq.size() != 0) drive_cycle();
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      chk("drain_empty", 512'(exp_q.size()), 0);
      chk("drain_idle", bus.tvalid, 0);
   endtask

   // scoreboard: every accepted beat must match the oldest expected beat
   always @(negedge clk) begin
      beat_t e;
      if (rst_n && bus.tvalid && bus.tready) begin
         chk("beat_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("tdata", bus.tdata, e.d);
            chk("tkeep", bus.tkeep, e.k);
            chk("tlast", bus.tlast, e.l);
            chk("tuser", bus.tuser, e.u);
         end
      end
   end

   initial begin
      bus.rx_ena  = '0;
      bus.rx_sop  = '0;
      bus.rx_eop  = '0;
      bus.rx_err  = '0;
      bus.rx_mty  = '0;
      bus.rx_data = '0;
      bus.tready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", bus.tvalid, 0);
      chk("rst_tlast", bus.tlast, 0);
      chk("rst_tuser", bus.tuser, 0);
      chk("rst_tkeep", bus.tkeep, 0);
      chk("rst_tdata", bus.tdata, 0);
      chk("rst_ovf", ovf, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // 64-byte packet in one cycle: single full beat after two cycles
      add_pkt(64, -1, 0, 0);
      drive_cycle();
      chk("lat_cycle1_tvalid", bus.tvalid, 0);
      @(posedge clk);
      #1;
      chk("lat_cycle2_tvalid", bus.tvalid, 1);
      chk("lat_cycle2_tlast", bus.tlast, 1);
      drain();
      // 65-byte packet starting at segment 2
      pad(2);
      add_pkt(65, -1, 0, 0);
      run();
      drain();
      // packet A ends at segment 1 (mty 4), packet B starts at segment 2
      add_pkt(28, -1, 0, 0);
      add_pkt(100, -1, 0, 0);
      run();
      drain();
      // longer packets with odd alignment
      pad(1);
      add_pkt(300, -1, 0, 0);
      pad(3);
      add_pkt(129, -1, 0, 0);
      run();
      drain();
      // error on eop segment, then error on sop segment of a multi-beat packet
      add_pkt(80, 4, 0, 0);
      add_pkt(150, 0, 0, 0);
      run();
      drain();
      // sop inside an open packet closes it
      add_pkt(48, -1, 1, 0);
      add_pkt(64, -1, 0, 0);
      run();
      drain();
      // overflow with tready low: 6 beats plus a truncated tlast beat
      bus.tready = 1'b0;
      add_pkt(1500, -1, 0, 7);
      run();
      repeat (3) @(posedge clk);
      #1;
      chk("ovf_cnt_one", ovf, 1);
      chk("stall_tvalid", bus.tvalid, 1);
      chk("stall_tdata_a", bus.tdata, exp_q[0].d);
      repeat (2) @(posedge clk);
      #1;
      chk("stall_tdata_b", bus.tdata, exp_q[0].d);
      chk("stall_tkeep", bus.tkeep, exp_q[0].k);
      bus.tready = 1'b1;
      drain();
      add_pkt(200, -1, 0, 0);
      run();
      drain();
      chk("ovf_cnt_hold", ovf, 1);
      // reset in the middle of a packet
      bus.tready = 1'b0;
      add_pkt(200, -1, 0, 0);
      drive_cycle();
      drive_cycle();
      chk("pre_rst_tvalid", bus.tvalid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_tvalid", bus.tvalid, 0);
      chk("rst_async_tkeep", bus.tkeep, 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.tready = 1'b1;
      run();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk("post_rst_quiet", bus.tvalid, 0);
      end
      chk("post_rst_ovf", ovf, 0);
      add_pkt(64, -1, 0, 0);
      run();
      drain();
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule

// File: doc/cmac_lbus2axi.md
CMAC_LBUS2AXI -- requirements
Module: cmac_lbus2axi

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, output FIFO depth in 512-bit beats; power of two, minimum 4.
REQ-002 CLK  input  1  single clock for all logic; LBUS RX and AXI4-Stream are both synchronous to it.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 CMAC_LBUS_RX.data[0..3]  input  4x128  LBUS RX segments; segment 0 is earliest; first byte of a segment is in bits [127:120].
REQ-005 CMAC_LBUS_RX.ena/sop/eop/err[0..3]  input  4x1 each  per-segment LBUS RX qualifiers.
REQ-006 CMAC_LBUS_RX.mty[0..3]  input  4x4  empty bytes in the segment; meaningful only when eop is set.
REQ-007 LBUS2AXI.tdata  output  512  beat data; first packet byte in tdata[7:0].
REQ-008 LBUS2AXI.tkeep  output  64  contiguous-from-LSB byte enables.
REQ-009 LBUS2AXI.tvalid / tlast  output  1 each  AXI4-Stream qualifiers.
REQ-010 LBUS2AXI.tuser  output  1  packet error flag, valid on the tlast beat.
REQ-011 LBUS2AXI.tready  input  1  downstream backpressure.
REQ-012 OVF_DROP_CNT  output  32  packets truncated because of FIFO overflow.

Function
REQ-013 LBUS RX has no backpressure; the block SHALL accept every enabled segment in every cycle.
REQ-014 Segment packing: enabled segments SHALL be appended in index order to a carry accumulator of 0-3 segments; each group of 4 forms one beat.
REQ-015 Packets SHALL be realigned so every AXI beat holds one packet only and the first beat of each packet starts at byte 0, regardless of the LBUS segment that carried sop.
REQ-016 On eop, the accumulator SHALL be flushed as a tlast beat; tkeep = 16 ones per full segment, plus (16 - mty) ones for the eop segment, upper bits zero.
REQ-017 One input cycle SHALL produce at most 2 beats (eop at segment k then sop at k+1, or carry 3 + 4 segments); the FIFO SHALL accept 2 writes per cycle.
REQ-018 Byte order: output byte j of a segment SHALL equal input bits [127-8j -: 8].
REQ-019 Packet FSM states IDLE and IN_PKT: IDLE->IN_PKT on ena&sop; IN_PKT->IDLE on ena&eop; enabled segments without sop in IDLE SHALL be discarded; sop in IN_PKT SHALL close the open packet with tuser=1 and start a new one.
REQ-020 err on any segment of a packet SHALL set tuser on that packet's tlast beat.
REQ-021 FIFO overflow: non-final writes SHALL require at least 3 free entries (one reserved); if refused, the partial accumulator SHALL be written as a tlast beat with tuser=1 into the reserved entry, remaining segments up to eop discarded, and OVF_DROP_CNT incremented once, saturating at 2^32-1.
REQ-022 Output SHALL obey AXI4-Stream: tdata/tkeep/tlast/tuser stable while tvalid & !tready; pop on tvalid & tready.
REQ-023 Latency from LBUS eop segment to tlast beat on an empty FIFO with tready=1 SHALL be 2 cycles.

Reset
REQ-024 While RST_N=0: tvalid=0, tlast=0, tuser=0, tkeep=0, tdata=0, OVF_DROP_CNT=0, FIFO empty, accumulator empty, FSM=IDLE.
REQ-025 Reset mid-packet SHALL discard all partial and queued data; after release, segments are discarded until the next sop.

Configuration
REQ-026 Macro CMAC_LBUS2AXI_ERR_FLAG_EN: when defined, tuser SHALL behave per REQ-019/020/021; when undefined, tuser SHALL be constant 0 while truncation and counting still occur.

Verification
REQ-027 64-byte packet, sop+eop in segments 0..3, mty[3]=0 -> one beat, tkeep=all ones, tlast=1, tdata[7:0]=first byte, 2-cycle latency.
REQ-028 65-byte packet with sop at segment 2 -> beats tkeep=all ones then tkeep=0x1, tlast on second.
REQ-029 Packet A eop at segment 1 (mty=4), packet B sop at segment 2 same cycle -> A tkeep=0x0FFF_FFFF tlast; B starts a new beat at byte 0.
REQ-030 tready=0 with 1500-byte packets streaming, FIFO_DEPTH=8 -> truncated tlast beat with tuser=1, OVF_DROP_CNT=1, next packet intact after tready=1.
REQ-031 err=1 on eop segment -> tuser=1 on tlast with macro defined, tuser=0 without.
REQ-032 RST_N pulsed low mid-packet -> tvalid=0 immediately, no output until the next sop.
